// File: rtl/count_capture.sv
// Timestamp capture stage: latches COUNT on each EVENT rising edge into a small
// FIFO drained by a VALID/READY handshake, with a sticky overflow flag for drops.
module count_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WIDTH-1:0]       COUNT,
    input  logic                   EVENT,
    output logic [WIDTH-1:0]       O,
    output logic                   VALID,
    input  logic                   READY,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   OVERFLOW
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ev_q, ev_d;
    logic             overflow_q, overflow_d;
    logic             cap, pop, push, drop, full;

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign cap  = EVENT & ~ev_q;
    assign full = (level_q == LW'(DEPTH));
    assign pop  = VALID & READY;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        ev_d       = EVENT;
        overflow_d = overflow_q | drop;

        if (push) begin
            mem_d[wr_ptr_q] = COUNT;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            // An EVENT held high through reset must not look like a fresh edge.
            ev_q       <= EVENT;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            ev_q       <= ev_d;
        end
    end

    // NOTE: storage is not reset; O is masked by VALID, so stale entries never escape.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign VALID    = (level_q != '0);
    assign O        = VALID ? mem_q[rd_ptr_q] : '0;
    assign LEVEL    = level_q;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_count_capture.sv
// Table-driven bench for count_capture: per-cycle vectors with expected outputs,
// plus a scoreboard queue that checks every value the consumer accepts.
module tb_count_capture;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] COUNT;
    logic       EVENT;
    logic [3:0] O;
    logic       VALID;
    logic       READY;
    logic [2:0] LEVEL;
    logic       OVERFLOW;

    count_capture #(.WIDTH(4), .DEPTH(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .COUNT    (COUNT),
        .EVENT    (EVENT),
        .O        (O),
        .VALID    (VALID),
        .READY    (READY),
        .LEVEL    (LEVEL),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       ev;
        logic       rdy;
        logic       sb;   // this capture must eventually be delivered
        logic [3:0] cnt;
        logic       xv;   // expected outputs after the edge
        logic [3:0] xo;
        logic [2:0] xl;
        logic       xf;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_q[$];
    int         run;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Append one cycle; COUNT follows a free-running counter held in 'run'.
    task automatic add(input logic rst, input logic ev, input logic rdy, input logic sbp,
                       input logic xv, input int xo, input int xl, input logic xf);
        vec_t v;
        v.rst = rst; v.ev = ev; v.rdy = rdy; v.sb = sbp;
        v.cnt = 4'(run);
        v.xv = xv; v.xo = 4'(xo); v.xl = 3'(xl); v.xf = xf;
        vecs.push_back(v);
        run = (run + 1) % 16;
    endtask

    task automatic idle(input int n, input logic rdy, input logic xf);
        for (int k = 0; k < n; k++) add(0, 0, rdy, 0, 0, 0, 0, xf);
    endtask

    task automatic apply(input int i, input vec_t v);
        // Consumer side: anything accepted this cycle must match the scoreboard head.
        if (VALID === 1'b1 && v.rdy) begin
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d.sb_underflow", i), 32'(O), 32'hffff_ffff);
            end else begin
                check($sformatf("v%0d.sb_data", i), 32'(O), 32'(sb_q.pop_front()));
            end
        end
        RESET = v.rst;
        EVENT = v.ev;
        READY = v.rdy;
        COUNT = v.cnt;
        if (v.sb) sb_q.push_back(v.cnt);
        if (v.rst) sb_q.delete();
        @(posedge CLK);
        #1;
        check($sformatf("v%0d.valid", i), 32'(VALID),    32'(v.xv));
        check($sformatf("v%0d.o", i),     32'(O),        32'(v.xo));
        check($sformatf("v%0d.level", i), 32'(LEVEL),    32'(v.xl));
        check($sformatf("v%0d.ovf", i),   32'(OVERFLOW), 32'(v.xf));
    endtask

    initial begin
        RESET = 1'b1; EVENT = 1'b1; READY = 1'b0; COUNT = '0;

        // Reset with EVENT held high, then EVENT stays high: no capture.
        run = 0;
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        // Single capture at COUNT=5, then one-cycle drain.
        run = 0;
        idle(5, 0, 0);
        add(0, 1, 0, 1, 1, 5, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);

        // Fill with 1,3,5,7; capture at 9 is dropped; drain; OVERFLOW sticky until reset.
        run = 0;
        idle(1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 1, 0);  add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1, 1, 2, 0);  add(0, 0, 0, 0, 1, 1, 2, 0);
        add(0, 1, 0, 1, 1, 1, 3, 0);  add(0, 0, 0, 0, 1, 1, 3, 0);
        add(0, 1, 0, 1, 1, 1, 4, 0);  add(0, 0, 0, 0, 1, 1, 4, 0);
        add(0, 1, 0, 0, 1, 1, 4, 1);  add(0, 0, 0, 0, 1, 1, 4, 1);
        add(0, 0, 1, 0, 1, 3, 3, 1);
        add(0, 0, 1, 0, 1, 5, 2, 1);
        add(0, 0, 1, 0, 1, 7, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        idle(2, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        // Full FIFO (2,4,6,8) with push and pop together at COUNT=10.
        run = 0;
        idle(2, 0, 0);
        add(0, 1, 0, 1, 1, 2, 1, 0);  add(0, 0, 0, 0, 1, 2, 1, 0);
        add(0, 1, 0, 1, 1, 2, 2, 0);  add(0, 0, 0, 0, 1, 2, 2, 0);
        add(0, 1, 0, 1, 1, 2, 3, 0);  add(0, 0, 0, 0, 1, 2, 3, 0);
        add(0, 1, 0, 1, 1, 2, 4, 0);  add(0, 0, 0, 0, 1, 2, 4, 0);
        add(0, 1, 1, 1, 1, 4, 4, 0);
        add(0, 0, 1, 0, 1, 6, 3, 0);
        add(0, 0, 1, 0, 1, 8, 2, 0);
        add(0, 0, 1, 0, 1, 10, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        // Captures at 14, 0, 2 across the counter wrap with READY held high.
        run = 12;
        idle(2, 1, 0);
        add(0, 1, 1, 1, 1, 14, 1, 0);  add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);   add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 2, 1, 0);   add(0, 0, 1, 0, 0, 0, 0, 0);

        // Reach LEVEL=3 with OVERFLOW=1, then reset alongside a capture and READY.
        run = 0;
        idle(1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 1, 0);  add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1, 1, 2, 0);  add(0, 0, 0, 0, 1, 1, 2, 0);
        add(0, 1, 0, 1, 1, 1, 3, 0);  add(0, 0, 0, 0, 1, 1, 3, 0);
        add(0, 1, 0, 1, 1, 1, 4, 0);  add(0, 0, 0, 0, 1, 1, 4, 0);
        add(0, 1, 0, 0, 1, 1, 4, 1);
        add(0, 0, 1, 0, 1, 3, 3, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
